// File: rtl/door_scheduler_if.sv
// door_scheduler_if: call/door handshake and car status bundle for door_scheduler
interface door_scheduler_if;
   logic [3:0] call_btn;
   logic       door_done;
   logic       door_open;
   logic [1:0] floor;
   logic       moving;
   logic       dir_up;
   logic [3:0] pending;
   logic       busy;

   modport master (
      output call_btn, door_done,
      input  door_open, floor, moving, dir_up, pending, busy
   );

   modport slave (
      input  call_btn, door_done,
      output door_open, floor, moving, dir_up, pending, busy
   );
endinterface

// File: rtl/door_scheduler.sv
// door_scheduler: four-floor SCAN car controller with door open/done handshake
module door_scheduler #(
   parameter int TRAVEL_TICKS = 8,
   parameter int OPEN_HOLD    = 4
) (
   input logic         clk,
   input logic         rst_a_n,
   door_scheduler_if.slave bus
);
   localparam int              HW         = OPEN_HOLD > 1 ? $clog2(OPEN_HOLD) : 1;
   localparam logic [15:0]     TRAVEL_MAX = 16'(TRAVEL_TICKS - 1);
   localparam logic [HW-1:0]   HOLD_MAX   = HW'(OPEN_HOLD - 1);

   typedef enum logic [2:0] {IDLE, MOVE, OPEN_REQ, WAIT_DONE, WAIT_REL} state_t;

   state_t      state;
   logic [15:0] timer;
   logic [HW-1:0] hold;
   logic        done_q;
   logic [1:0]  next_floor;
   logic [3:0]  held;

   function automatic logic [3:0] bit_of(input logic [1:0] f);
      return 4'b0001 << f;
   endfunction

   // keep the current direction while calls lie ahead, otherwise turn toward calls behind
   function automatic logic pick_dir(input logic [1:0] f, input logic d, input logic [3:0] p);
      logic above, below;
      above = |(p & (4'b1110 << f));
      below = |(p & ~(4'b1111 << f));
      return d ? (above | ~below) : (above & ~below);
   endfunction

   // one-floor step in the scan direction, clamped at the shaft ends; calls merged into latched set
   always_comb begin
      next_floor = bus.dir_up ? (bus.floor == 2'd3 ? bus.floor : bus.floor + 2'd1)
                              : (bus.floor == 2'd0 ? bus.floor : bus.floor - 2'd1);
      held       = bus.pending | bus.call_btn;
   end

   // scheduler FSM with registered outputs; the served floor's call is cleared on OPEN_REQ entry and while in it
   always_ff @(posedge clk or negedge rst_a_n)
      if (!rst_a_n) begin
         state         <= IDLE;
         timer         <= '0;
         hold          <= '0;
         done_q        <= 1'b0;
         bus.floor     <= 2'd0;
         bus.dir_up    <= 1'b1;
         bus.pending   <= 4'b0000;
         bus.door_open <= 1'b0;
         bus.moving    <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         done_q      <= bus.door_done;
         bus.pending <= held;
         case (state)
            IDLE:
               if (bus.pending[bus.floor]) begin
                  state         <= OPEN_REQ;
                  hold          <= HOLD_MAX;
                  bus.door_open <= 1'b1;
                  bus.busy      <= 1'b1;
                  bus.pending   <= held & ~bit_of(bus.floor);
               end else if (|bus.pending) begin
                  state      <= MOVE;
                  timer      <= TRAVEL_MAX;
                  bus.dir_up <= pick_dir(bus.floor, bus.dir_up, bus.pending);
                  bus.moving <= 1'b1;
                  bus.busy   <= 1'b1;
               end
            MOVE:
               if (timer != 16'd0)
                  timer <= timer - 16'd1;
               else begin
                  bus.floor <= next_floor;
                  if (bus.pending[next_floor]) begin
                     state         <= OPEN_REQ;
                     hold          <= HOLD_MAX;
                     bus.door_open <= 1'b1;
                     bus.moving    <= 1'b0;
                     bus.pending   <= held & ~bit_of(next_floor);
                  end else begin
                     timer      <= TRAVEL_MAX;
                     bus.dir_up <= pick_dir(next_floor, bus.dir_up, bus.pending);
                  end
               end
            OPEN_REQ: begin
               bus.pending <= held & ~bit_of(bus.floor);
               if (hold != '0)
                  hold <= hold - HW'(1);
               else begin
                  state         <= WAIT_DONE;
                  bus.door_open <= 1'b0;
               end
            end
            WAIT_DONE:
               if (bus.door_done && !done_q)
                  state <= WAIT_REL;
            WAIT_REL:
               if (!bus.door_done) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            default: state <= IDLE;
         endcase
      end
endmodule
